// File: rtl/ysyx_23060201_ifu_pf.sv
// Instruction fetch unit with prefetch.
// Holds the fetch PC, issues in-order word reads over a valid/ready port,
// buffers returned words in a small FIFO and hands them to decode. A redirect
// flushes the buffer; words still in flight at that point are discarded.
module ysyx_23060201_ifu_pf #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MBASE      = 32'h8000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_err
);

  localparam int                    PW      = $clog2(FIFO_DEPTH);
  localparam int                    CW      = PW + 1;
  localparam logic [CW:0]           DEPTH_W = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic [CW-1:0]         cnt_q, cnt_d, inflt_q, inflt_d, drop_q, drop_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;      // instruction FIFO pointers
  logic [PW-1:0]         prd_q, prd_d, pwr_q, pwr_d;  // in-flight PC FIFO pointers

  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] einst_q, einst_d;
  logic [FIFO_DEPTH-1:0]                 eerr_q, eerr_d;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ppc_q, ppc_d;

  logic pop, credit_ok, pc_ok, req_fire, fault_push, rsp_keep, push;

  // Issue control. The entry popped this cycle frees its slot at the same
  // edge, so it counts as credit; without this a k=1 memory stalls every
  // other cycle. The sum inflt+cnt after the edge never exceeds FIFO_DEPTH.
  always_comb begin
    pop        = (cnt_q != '0) & out_ready;
    credit_ok  = ({1'b0, inflt_q} + {1'b0, cnt_q}) < (DEPTH_W + {{CW{1'b0}}, pop});
    pc_ok      = fpc_q >= MBASE;
    req_valid  = rst_n & credit_ok & pc_ok & ~redirect_valid;
    req_fire   = req_valid & req_ready;
    // Faults wait for an empty pipe so they stay in program order.
    fault_push = rst_n & credit_ok & ~pc_ok & ~redirect_valid &
                 (inflt_q == '0) & (drop_q == '0);
    rsp_keep   = rsp_valid & (drop_q == '0) & ~redirect_valid;
    push       = rsp_keep | fault_push;
  end

  // Next-state for fetch PC, counters and both FIFOs.
  always_comb begin
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;
    inflt_d = inflt_q + CW'(req_fire) - CW'(rsp_valid);
    drop_d  = drop_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    prd_d   = prd_q;
    pwr_d   = pwr_q;
    epc_d   = epc_q;
    einst_d = einst_q;
    eerr_d  = eerr_q;
    ppc_d   = ppc_q;

    if (req_fire | fault_push) fpc_d = fpc_q + STEP;

    // Every response, kept or dropped, retires the oldest in-flight PC.
    if (req_fire) begin
      ppc_d[pwr_q] = fpc_q;
      pwr_d        = pwr_q + PW'(1);
    end
    if (rsp_valid) prd_d = prd_q + PW'(1);

    if (redirect_valid) begin
      fpc_d  = redirect_pc;
      // Everything still outstanding after this edge belongs to the old path.
      drop_d = inflt_q - CW'(rsp_valid);
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
    end else begin
      if (rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
        epc_d[wr_q]   = rsp_keep ? ppc_q[prd_q] : fpc_q;
        einst_d[wr_q] = rsp_keep ? rsp_data : '0;
        eerr_d[wr_q]  = ~rsp_keep;
        wr_d          = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q   <= RESET_PC;
      cnt_q   <= '0;
      inflt_q <= '0;
      drop_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      prd_q   <= '0;
      pwr_q   <= '0;
      epc_q   <= '0;
      einst_q <= '0;
      eerr_q  <= '0;
      ppc_q   <= '0;
    end else begin
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
      inflt_q <= inflt_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      prd_q   <= prd_d;
      pwr_q   <= pwr_d;
      epc_q   <= epc_d;
      einst_q <= einst_d;
      eerr_q  <= eerr_d;
      ppc_q   <= ppc_d;
    end
  end

  assign req_addr  = fpc_q;
  assign out_valid = cnt_q != '0;
  assign out_pc    = epc_q[rd_q];
  assign out_inst  = einst_q[rd_q];
  assign out_err   = eerr_q[rd_q];

endmodule

// File: tb/tb_ysyx_23060201_ifu_pf.sv
// Directed bench for ysyx_23060201_ifu_pf with an in-order memory of
// configurable latency k and a log of issued requests / delivered words.
module tb_ysyx_23060201_ifu_pf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;

  ysyx_23060201_ifu_pf dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  ent_t        out_log[$];
  int          k, cyc, last_due, mark;
  int          total, bad;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, log handshakes, cross the edge.
  task automatic step();
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    if (req_valid && req_ready) begin
      int due = cyc + k;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{req_addr, due});
      req_log.push_back(req_addr);
    end
    if (out_valid && out_ready && !redirect_valid)
      out_log.push_back({out_pc, out_inst, out_err});
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mq.delete();
    req_log.delete();
    out_log.delete();
    last_due = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    total = 0; bad = 0; k = 1; cyc = 0; last_due = -1; mark = 0;

    // Reset values
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_addr", req_addr, 32'h8000_0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", out_err, 1'b0);

    // 1: first fetches, k=1, consecutive requests, one out per cycle
    do_reset(); k = 1; req_ready = 1'b1; out_ready = 1'b1;
    #1;
    chk("t1_req0_valid", req_valid, 1'b1);
    chk("t1_req0_addr", req_addr, 32'h8000_0000);
    step();
    chk("t1_req1_addr", req_addr, 32'h8000_0004);
    chk("t1_out_empty", out_valid, 1'b0);
    step();
    chk("t1_out0_valid", out_valid, 1'b1);
    chk("t1_out0_pc", out_pc, 32'h8000_0000);
    chk("t1_out0_inst", out_inst, mem(32'h8000_0000));
    chk("t1_req2_valid", req_valid, 1'b1);
    chk("t1_req2_addr", req_addr, 32'h8000_0008);
    step();
    chk("t1_out1_pc", out_pc, 32'h8000_0004);
    chk("t1_out1_inst", out_inst, mem(32'h8000_0004));
    chk("t1_req3_addr", req_addr, 32'h8000_000C);

    // 2: back-pressure stops issue at FIFO_DEPTH, then resumes in order
    do_reset(); k = 1; req_ready = 1'b1; out_ready = 1'b0;
    repeat (5) step();
    chk("t2_nreq", req_log.size(), 2);
    chk("t2_req_low", req_valid, 1'b0);
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_head_pc", out_pc, 32'h8000_0000);
    out_ready = 1'b1;
    repeat (8) step();
    chk("t2_nout_ok", out_log.size() >= 6, 1'b1);
    if (out_log.size() >= 6 && req_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t2_out_pc", out_log[i].pc, 32'h8000_0000 + 32'(4 * i));
        chk("t2_out_inst", out_log[i].inst, mem(32'h8000_0000 + 32'(4 * i)));
        chk("t2_req_addr", req_log[i], 32'h8000_0000 + 32'(4 * i));
      end
    end

    // 3: redirect with two requests outstanding, k=3
    do_reset(); k = 3; req_ready = 1'b1; out_ready = 1'b1;
    repeat (2) step();
    chk("t3_credit_stall", req_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("t3_redir_addr", req_addr, 32'h8000_0100);
    repeat (10) step();
    chk("t3_nout_ok", out_log.size() >= 2, 1'b1);
    if (out_log.size() >= 2) begin
      chk("t3_first_pc", out_log[0].pc, 32'h8000_0100);
      chk("t3_first_inst", out_log[0].inst, mem(32'h8000_0100));
      chk("t3_second_pc", out_log[1].pc, 32'h8000_0104);
    end

    // 4: redirect in the same cycle as the response for 0x8000_0008, k=2
    do_reset(); k = 2; req_ready = 1'b1; out_ready = 1'b1;
    repeat (5) step();
    mark = out_log.size();
    chk("t4_pre_out", mark, 2);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    chk("t4_drop", dut.drop_q, 1);
    chk("t4_inflt", dut.inflt_q, 1);
    chk("t4_flushed", out_valid, 1'b0);
    repeat (10) step();
    chk("t4_nout_ok", out_log.size() >= mark + 2, 1'b1);
    if (out_log.size() >= mark + 2) begin
      chk("t4_first_pc", out_log[mark].pc, 32'h8000_0200);
      chk("t4_second_pc", out_log[mark + 1].pc, 32'h8000_0204);
    end

    // 5: fault fetch below MBASE, then wrap into memory
    do_reset(); k = 1; req_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h7FFF_FFFC;
    #1;
    chk("t5_redir_low", req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    chk("t5_no_req", req_valid, 1'b0);
    chk("t5_fpc", req_addr, 32'h7FFF_FFFC);
    step();
    chk("t5_out_valid", out_valid, 1'b1);
    chk("t5_out_pc", out_pc, 32'h7FFF_FFFC);
    chk("t5_out_inst", out_inst, 32'h0);
    chk("t5_out_err", out_err, 1'b1);
    chk("t5_next_valid", req_valid, 1'b1);
    chk("t5_next_addr", req_addr, 32'h8000_0000);
    repeat (4) step();
    chk("t5_nreq_ok", req_log.size() >= 1, 1'b1);
    chk("t5_nout_ok", out_log.size() >= 2, 1'b1);
    if (req_log.size() >= 1 && out_log.size() >= 2) begin
      chk("t5_first_req", req_log[0], 32'h8000_0000);
      chk("t5_mem_pc", out_log[1].pc, 32'h8000_0000);
      chk("t5_mem_err", out_log[1].err, 1'b0);
      chk("t5_mem_inst", out_log[1].inst, mem(32'h8000_0000));
    end

    // 6: asynchronous reset pulse between edges with the FIFO full
    do_reset(); k = 1; req_ready = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    chk("t6_full_valid", out_valid, 1'b1);
    chk("t6_full_cnt", dut.cnt_q, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", out_valid, 1'b0);
    chk("t6_async_req_valid", req_valid, 1'b0);
    mq.delete(); req_log.delete(); out_log.delete(); last_due = -1;
    #1 rst_n = 1'b1;
    #1;
    cyc = 0;
    chk("t6_restart_valid", req_valid, 1'b1);
    chk("t6_restart_addr", req_addr, 32'h8000_0000);
    out_ready = 1'b1;
    repeat (4) step();
    chk("t6_nout_ok", out_log.size() >= 1, 1'b1);
    if (out_log.size() >= 1)
      chk("t6_first_pc", out_log[0].pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
